// File: rtl/sram_arbiter.sv
// Shares one SRAM controller among NUM_CLIENTS requesters; client 0 (display) can take strict priority, bounded by a starvation guard.
// Latency: gnt one cycle after req is seen in IDLE, done one cycle after mem_ready; clients are held off by keeping req high until their gnt.
module sram_arbiter #(
  parameter int NUM_CLIENTS  = 2,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          display_window,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        done,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   winner, last_grant, rr_idx, sel;
  logic               we_q, rr_found, others, pick0, grant;
  logic [CNT_W-1:0]   starve_cnt;
  int                 cand;

  assign others = |req[NUM_CLIENTS-1:1];
  assign pick0  = display_window && req[0] && (starve_cnt < LIMIT);
  assign sel    = pick0 ? '0 : rr_idx;
  assign grant  = (state == IDLE) && (|req);

  // Round-robin search starting just after the previous winner.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = (int'(last_grant) + k) % NUM_CLIENTS;
      if (!rr_found && req[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (|req) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt   = WAIT;
        gnt[winner] = 1'b1;
        mem_read    = ~we_q;
        mem_write   = we_q;
      end
      WAIT:  if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winner     <= '0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      done       <= '0;
      starve_cnt <= '0;
      last_grant <= IDX_W'(NUM_CLIENTS - 1);
    end else begin
      done <= '0;
      if (grant) begin
        winner     <= sel;
        last_grant <= sel;
        we_q       <= we[sel];
        mem_addr   <= ADDR_W'(addr >> (sel * ADDR_W));
        mem_wdata  <= DATA_W'(wdata >> (sel * DATA_W));
      end
      if (state == WAIT && mem_ready) begin
        done <= NUM_CLIENTS'(1) << winner;
        if (!we_q) rdata <= mem_rdata;
      end
      // The guard only counts display grants that actually made someone else wait.
      if (!others)
        starve_cnt <= '0;
      else if (grant && sel == '0)
        starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
      else if (grant)
        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a transaction-level reference model checked every cycle.
module tb_sram_arbiter;
  localparam int N   = 4;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           display_window = 1'b0;
  logic [N-1:0]   req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]   gnt, done;
  logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic           mem_read, mem_write, mem_ready, busy;
  logic           resp_ready = 1'b0, force_ready = 1'b0;
  logic [DW-1:0]  resp_data = '0;
  int             auto_lat = 0;
  int             checks = 0, failures = 0;

  assign mem_ready = resp_ready | force_ready;
  assign mem_rdata = resp_data;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .display_window(display_window),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory responder: raises mem_ready auto_lat cycles after a grant.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_lat > 0 && gnt != '0) begin
        repeat (auto_lat) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
      end
    end
  end

  // Reference model: phase 0 idle, 1 grant cycle, 2 waiting for memory.
  int            ph = 0, mw = 0, mlast = N-1, mstarve = 0;
  logic          mwr = 1'b0;
  logic [AW-1:0] ma = '0;
  logic [DW-1:0] mwd = '0, mrd = '0;
  logic [N-1:0]  mdone = '0;

  always @(posedge clk) begin
    int w;
    logic oth;
    if (reset) begin
      ph = 0; mw = 0; mwr = 1'b0; ma = '0; mwd = '0; mrd = '0;
      mdone = '0; mlast = N-1; mstarve = 0;
    end else begin
      oth   = |req[N-1:1];
      mdone = '0;
      if (ph == 0) begin
        if (req != '0) begin
          w = -1;
          if (display_window && req[0] && mstarve < LIM) w = 0;
          else
            for (int k = 1; k <= N; k++)
              if (w < 0 && ((req >> ((mlast + k) % N)) & 4'd1) != 0) w = (mlast + k) % N;
          if (w == 0 && oth) mstarve = (mstarve < LIM) ? mstarve + 1 : LIM;
          else if (w != 0) mstarve = 0;
          mlast = w; mw = w;
          mwr = ((we >> w) & 4'd1) != 0;
          ma  = AW'(addr >> (w * AW));
          mwd = DW'(wdata >> (w * DW));
          ph  = 1;
        end
      end else if (ph == 1) begin
        ph = 2;
      end else if (mem_ready) begin
        if (!mwr) mrd = mem_rdata;
        mdone = N'(1) << mw;
        ph = 0;
      end
      if (!oth) mstarve = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("m_gnt",   32'(gnt),   (ph == 1) ? 32'(N'(1) << mw) : 32'd0);
    check("m_read",  32'(mem_read),  32'(ph == 1 && !mwr));
    check("m_write", 32'(mem_write), 32'(ph == 1 && mwr));
    check("m_addr",  32'(mem_addr),  32'(ma));
    check("m_wdata", 32'(mem_wdata), 32'(mwd));
    check("m_rdata", 32'(rdata),     32'(mrd));
    check("m_done",  32'(done),      32'(mdone));
    check("m_busy",  32'(busy),      32'(ph != 0));
  endtask

  // One cycle: outputs sampled 2 time units after the edge, inputs driven right after.
  task automatic tick();
    @(posedge clk); #2;
    cmp_all();
  endtask

  task automatic wait_gnt(output int g);
    g = -1;
    for (int i = 0; i < 40 && g < 0; i++) begin
      tick();
      if (gnt != '0)
        for (int j = 0; j < N; j++) if (((gnt >> j) & 4'd1) != 0) g = j;
    end
    if (g < 0) begin
      checks++; failures++;
      $display("FAIL gnt_timeout actual=none required=grant within 40 cycles");
    end
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int st_exp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int g;

  initial begin
    tick(); tick();
    check("rst_gnt",  32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Round-robin from reset: all request, each drops after its grant.
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
    auto_lat = 1; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      check("rr_order", 32'(g), 32'(rr_exp[i]));
      if (g >= 0) req = req & ~(N'(1) << g);
    end
    req[0] = 1'b1;
    wait_gnt(g);
    check("rr_rerequest", 32'(g), 32'(rr_exp[4]));
    req = '0;
    repeat (6) tick();

    // Single read with memory answering 3 cycles after the grant.
    auto_lat = 3; resp_data = 16'hBEEF; we = '0; addr[0 +: AW] = 18'h00123; req = 4'b0001;
    tick();
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_mem_read", 32'(mem_read), 32'h1);
    check("rd_mem_addr", 32'(mem_addr), 32'h00123);
    req = '0;
    tick();
    check("rd_read_pulse", 32'(mem_read), 32'h0);
    check("rd_addr_hold", 32'(mem_addr), 32'h00123);
    tick(); tick();
    check("rd_done_early", 32'(done), 32'h0);
    tick();
    check("rd_done", 32'(done), 32'h1);
    check("rd_rdata", 32'(rdata), 32'hBEEF);

    // Write from client 1, back-to-back with the completing read.
    auto_lat = 1; resp_data = 16'h1111; we = 4'b0010;
    addr[AW +: AW] = 18'h3FFFF; wdata[DW +: DW] = 16'h5A5A; req = 4'b0010;
    tick();
    check("wr_gnt", 32'(gnt), 32'h2);
    check("wr_mem_write", 32'(mem_write), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h3FFFF);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h5A5A);
    req = '0; we = '0;
    tick(); tick();
    check("wr_done", 32'(done), 32'h2);
    check("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    repeat (4) tick();

    // Display priority with starvation guard.
    display_window = 1'b1; req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      wait_gnt(g);
      check("starve_seq", 32'(g), 32'(st_exp[i]));
    end
    req = '0; display_window = 1'b0; auto_lat = 0;
    repeat (6) tick();

    // Stray mem_ready in IDLE and in the grant cycle is ignored.
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick();
    check("stray_idle_busy", 32'(busy), 32'h0);
    check("stray_idle_done", 32'(done), 32'h0);
    addr[0 +: AW] = 18'h00042; req = 4'b0001;
    tick();
    check("stray_gnt", 32'(gnt), 32'h1);
    force_ready = 1'b1; req = '0;
    tick();
    check("stray_issue_busy", 32'(busy), 32'h1);
    force_ready = 1'b0;
    tick();
    check("stray_wait_busy", 32'(busy), 32'h1);
    check("stray_no_done", 32'(done), 32'h0);
    force_ready = 1'b1; resp_data = 16'hCAFE;
    tick();
    force_ready = 1'b0;
    check("stray_done", 32'(done), 32'h1);
    check("stray_rdata", 32'(rdata), 32'hCAFE);
    repeat (3) tick();

    // Reset while waiting on memory abandons the transaction.
    req = 4'b0011;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rstw_gnt", 32'(gnt), 32'h0);
    check("rstw_done", 32'(done), 32'h0);
    check("rstw_busy", 32'(busy), 32'h0);
    check("rstw_addr", 32'(mem_addr), 32'h0);
    check("rstw_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    tick();
    check("rstw_next_gnt", 32'(gnt), 32'h1);
    req = '0; force_ready = 1'b1;
    tick(); tick();
    force_ready = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 2, number of SRAM clients (legal 2..8); client 0 is the display client.
REQ-002 Parameter ADDR_W, default 18, SRAM word address width.
REQ-003 Parameter DATA_W, default 16, SRAM word width.
REQ-004 Parameter STARVE_LIMIT, default 64, maximum consecutive client-0 grants while any other client is pending (legal 1..1023).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 display_window  in  1  high = client 0 has strict priority; low = pure round-robin.
REQ-008 req  in  NUM_CLIENTS  per-client request level; held with we/addr/wdata stable until that client's gnt.
REQ-009 we  in  NUM_CLIENTS  per-client 1 = write, 0 = read.
REQ-010 addr  in  NUM_CLIENTS*ADDR_W  client i at bits [i*ADDR_W +: ADDR_W].
REQ-011 wdata  in  NUM_CLIENTS*DATA_W  client i at bits [i*DATA_W +: DATA_W].
REQ-012 gnt  out  NUM_CLIENTS  one-cycle accept pulse, one-hot.
REQ-013 done  out  NUM_CLIENTS  one-cycle completion pulse, one-hot.
REQ-014 rdata  out  DATA_W  read data; valid only while done is high for a read.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_read  out  1; mem_write  out  1 -- outputs to the SRAM controller.
REQ-016 mem_ready  in  1; mem_rdata  in  DATA_W -- completion inputs from the SRAM controller.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT. IDLE -> ISSUE when |req; ISSUE -> WAIT unconditionally; WAIT -> IDLE on mem_ready.
REQ-019 Arbitration is evaluated in IDLE only. The winner, its we, addr and wdata are latched on the IDLE->ISSUE edge.
REQ-020 Winner selection, display_window=1: client 0 if req[0] and starve_cnt < STARVE_LIMIT; otherwise round-robin over all requesters.
REQ-021 Winner selection, display_window=0: round-robin. Search starts at (last_grant+1) mod NUM_CLIENTS and wraps; first requester found wins.
REQ-022 last_grant updates to the winner on every grant.
REQ-023 starve_cnt increments on a client-0 grant while any req[i], i>0, is high, saturating at STARVE_LIMIT.
REQ-024 starve_cnt clears on any grant to i>0, and on any cycle in which no req[i], i>0, is high.
REQ-025 In ISSUE, for exactly one cycle: gnt[winner]=1; mem_read=~we or mem_write=we; mem_addr and mem_wdata driven from the latched values.
REQ-026 mem_addr and mem_wdata hold their latched values through WAIT.
REQ-027 mem_ready is ignored in IDLE and ISSUE.
REQ-028 On the WAIT cycle with mem_ready=1: rdata <= mem_rdata (reads only; rdata otherwise unchanged), and done[winner]=1 on the following cycle, which is IDLE.
REQ-029 Arbitration may occur in that same IDLE cycle, giving back-to-back grants with a 3-cycle minimum period.
REQ-030 Latency: req seen in IDLE at cycle t -> gnt at t+1 -> done at t+k+2, where mem_ready is high at cycle t+1+k, k>=1.
REQ-031 display_window changes mid-transaction do not affect the current transaction; the new value applies at the next IDLE evaluation.
REQ-032 gnt and done are never high in the same cycle for the same client, and are never multi-hot.

Reset
REQ-033 On reset: state=IDLE; gnt, done, mem_read, mem_write, busy = 0; mem_addr, mem_wdata, rdata = 0; starve_cnt=0; last_grant=NUM_CLIENTS-1.
REQ-034 Reset mid-transaction abandons it without issuing done; the client must re-request.
REQ-035 The first grant after reset with all clients requesting and display_window=0 goes to client 0.

Verification
REQ-036 Single read: N=2, req=01, we=0, addr0=0x00123, mem_ready 3 cycles after ISSUE, mem_rdata=0xBEEF -> gnt=01 at t+1, mem_read one cycle, done=01 with rdata=0xBEEF at t+5.
REQ-037 Round-robin: display_window=0, N=4, req=1111 held, each request released after its gnt -> grant order 0,1,2,3; after 0 re-raises, it wins again.
REQ-038 Starvation: display_window=1, N=2, req=11 held, STARVE_LIMIT=4, mem_ready immediate -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-039 Write: req=10, we=10, addr1=0x3FFFF, wdata1=0x5A5A -> mem_write pulse with mem_addr=0x3FFFF and mem_wdata=0x5A5A; done=10; rdata unchanged.
REQ-040 Reset in WAIT: assert reset for 1 cycle before mem_ready -> no done pulse; all outputs 0; next grant goes to client 0.
REQ-041 Stray mem_ready: assert mem_ready while in IDLE and in ISSUE -> no done pulse and no state change.
